dmem_arbiter: RTL

- Shares the single-port 1024x32 data memory (async read, sync write on posedge clk when ena && wena) between two requesters: port A (CPU MEM stage) and port B (DMA / test-loader / debug).
- Performs per-cycle arbitration, drives the memory control and address/data pins, and returns registered read data to the winning requester.
- Sits directly between the requesters and the data memory; it is the only driver of the memory's ram_ena, wena, addr and data_in.

---
 rtl/dmem_arb_pkg.sv | 17 +
 rtl/arb2_core.sv | 71 +++++++
 rtl/dmem_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory arbiter: bus widths, priority modes,
// requester port indices and the starvation counter width.
package dmem_arb_pkg;

    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned WCNT_W    = 4;

    localparam int unsigned PRI_RR    = 0;
    localparam int unsigned PRI_FIXED = 1;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

endpackage

// File: rtl/arb2_core.sv
// Two-requester grant selection with round-robin or fixed-priority policy.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   a_req_i/b_req_i request lines from port A / port B
//   a_gnt_c/b_gnt_c combinational one-hot (or zero) grants
module arb2_core
    import dmem_arb_pkg::*;
#(
    parameter int unsigned PRIORITY_MODE = PRI_RR,
    parameter int unsigned MAX_WAIT      = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic a_req_i,
    input  logic b_req_i,
    output logic a_gnt_c,
    output logic b_gnt_c
);

    port_e              last_gnt_q, last_gnt_d;
    logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               b_wins;

    // Contention state register
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q <= PORT_B;
            wait_cnt_q <= '0;
        end else begin
            last_gnt_q <= last_gnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Grant selection and next contention state
    always_comb begin
        a_gnt_c    = 1'b0;
        b_gnt_c    = 1'b0;
        last_gnt_d = last_gnt_q;
        wait_cnt_d = '0;

        if (PRIORITY_MODE == PRI_FIXED) begin
            b_wins = (wait_cnt_q == WCNT_W'(MAX_WAIT));
        end else begin
            b_wins = (last_gnt_q == PORT_A);
        end

        unique case ({a_req_i, b_req_i})
            2'b10:   a_gnt_c = 1'b1;
            2'b01:   b_gnt_c = 1'b1;
            2'b11: begin
                b_gnt_c = b_wins;
                a_gnt_c = !b_wins;
            end
            default: ;
        endcase

        if (a_gnt_c) begin
            last_gnt_d = PORT_A;
        end else if (b_gnt_c) begin
            last_gnt_d = PORT_B;
        end

        // Starvation counter only counts consecutive denied B cycles
        if ((PRIORITY_MODE == PRI_FIXED) && b_req_i && !b_gnt_c) begin
            wait_cnt_d = (wait_cnt_q == WCNT_W'(MAX_WAIT)) ? wait_cnt_q
                                                           : wait_cnt_q + WCNT_W'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between port A (CPU) and port B (DMA).
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata         port A request fields (held until a_gnt)
//   a_gnt                             combinational grant for A
//   a_rvalid/a_rdata                  registered A read response
//   b_*                               same set for port B
//   mem_ena/mem_wena/mem_addr/mem_wdata  memory control and write pins
//   mem_rdata                         async memory read data (floating when idle)
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W        = dmem_arb_pkg::ADDR_W,
    parameter int unsigned DATA_W        = dmem_arb_pkg::DATA_W,
    parameter int unsigned PRIORITY_MODE = PRI_RR,
    parameter int unsigned MAX_WAIT      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_ena,
    output logic              mem_wena,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic              a_rvalid_q, a_rvalid_d;
    logic              b_rvalid_q, b_rvalid_d;
    logic [DATA_W-1:0] a_rdata_q,  a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q,  b_rdata_d;

    arb2_core #(
        .PRIORITY_MODE (PRIORITY_MODE),
        .MAX_WAIT      (MAX_WAIT)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .a_req_i (a_req),
        .b_req_i (b_req),
        .a_gnt_c (a_gnt),
        .b_gnt_c (b_gnt)
    );

    // Memory pin mux; idle drives all-zero so no float reaches the memory
    always_comb begin
        mem_ena   = 1'b0;
        mem_wena  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (a_gnt) begin
            mem_ena   = 1'b1;
            mem_wena  = a_we && !rst;
            mem_addr  = a_addr;
            mem_wdata = a_wdata;
        end else if (b_gnt) begin
            mem_ena   = 1'b1;
            mem_wena  = b_we && !rst;
            mem_addr  = b_addr;
            mem_wdata = b_wdata;
        end
    end

    // mem_rdata is only looked at on a granted read, so idle float is ignored
    always_comb begin
        a_rvalid_d = a_gnt && !a_we;
        b_rvalid_d = b_gnt && !b_we;
        a_rdata_d  = a_rvalid_d ? mem_rdata : a_rdata_q;
        b_rdata_d  = b_rvalid_d ? mem_rdata : b_rdata_q;
    end

    // Response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;

endmodule
